// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t;
  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );
endinterface

// File: rtl/nibble_serial_adder_ripple.sv
// Four-bit ripple-carry adder slice, pure dataflow.
module ripple_adder_4bit_dataflow (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);
  logic [4:0] c;

  assign c[0] = cin_i;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end
  assign cout_o = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// Serial WIDTH-bit adder: one 4-bit slice reused per nibble, carry registered between nibbles.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int SEL_W   = $clog2(WIDTH);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_chk
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  nsa_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic [SEL_W-1:0]  base;
  logic [3:0]        s_sum;
  logic              s_cout;
  logic              last_nibble;

  assign base        = SEL_W'({idx_q, 2'b00});
  assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));

  ripple_adder_4bit_dataflow u_slice (
    .a_i    (a_q[base +: NIBBLE_W]),
    .b_i    (b_q[base +: NIBBLE_W]),
    .cin_i  (carry_q),
    .sum_o  (s_sum),
    .cout_o (s_cout)
  );

  // Handshake flags come from state only; reset forces both low.
  assign bus.in_ready  = rst_n & (state_q == IDLE);
  assign bus.out_valid = rst_n & (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[base +: NIBBLE_W] = s_sum;
        carry_d = s_cout;
        idx_d   = idx_q + 1'b1;
        if (last_nibble) begin
          cout_d  = s_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Operand copies are pure data and need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16 plus a WIDTH=4 instance).
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) bus ();
  nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

  nibble_serial_adder #(.WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  nibble_serial_adder #(.WIDTH(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  int total = 0;
  int bad = 0;
  logic [16:0] sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every delivered result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        chk("result", {15'd0, bus.cout, bus.sum}, {15'd0, sb_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [16:0] exp, input bit push);
    int guard = 0;
    while (!bus.in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (guard >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.in_valid = 1'b1;
    if (push) sb_q.push_back(exp);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (!bus.out_valid && cnt < 50) begin
      tick();
      cnt++;
    end
    if (cnt >= 50) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cnt;
    time t_prev, t_now;
    logic [15:0] ra, rb;
    logic rc;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sum", {16'd0, bus.sum}, 32'd0);
    chk("rst_cout", {31'd0, bus.cout}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // 1: nibble carry into bit 8, latency
    send(16'h00FF, 16'h0001, 1'b0, {1'b0, 16'h0100}, 1'b1);
    wait_valid(cnt);
    chk("latency", cnt, 32'd4);
    tick();

    // 2: carry across all nibble boundaries
    send(16'hFFFF, 16'h0000, 1'b1, {1'b1, 16'h0000}, 1'b1);
    wait_valid(cnt);
    tick();

    // 3: back-pressure with ignored in_valid pulses
    bus.out_ready = 1'b0;
    send(16'h0F0F, 16'h0101, 1'b1, {1'b0, 16'h1011}, 1'b1);
    wait_valid(cnt);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = (i % 2 == 0);
      bus.a = 16'hDEAD;
      tick();
      chk("hold_sum", {16'd0, bus.sum}, 32'h1011);
      chk("hold_cout", {31'd0, bus.cout}, 32'd0);
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("ready_after_hs", {31'd0, bus.in_ready}, 32'd1);
    chk("valid_after_hs", {31'd0, bus.out_valid}, 32'd0);

    // 4: reset in the second nibble aborts the op
    send(16'h7777, 16'h1111, 1'b0, 17'd0, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);
    send(16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}, 1'b1);
    wait_valid(cnt);
    tick();

    // 5: operand change after acceptance, then back-to-back throughput
    send(16'h0001, 16'h0001, 1'b0, {1'b0, 16'h0002}, 1'b1);
    bus.a = 16'hAAAA;
    wait_valid(cnt);
    tick();
    send(16'h0010, 16'h0020, 1'b0, {1'b0, 16'h0030}, 1'b1);
    t_prev = $time;
    for (int i = 0; i < 3; i++) begin
      send(16'h1000 * i[15:0], 16'h0F00, 1'b1, {1'b0, 16'h1000 * i[15:0] + 16'h0F01}, 1'b1);
      t_now = $time;
      chk("accept_period", 32'(t_now - t_prev), 32'd60);
      t_prev = t_now;
    end
    wait_valid(cnt);
    tick();

    // 6: random operands against a + b + cin
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      send(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {16'd0, rc}, 1'b1);
    end
    wait_valid(cnt);
    tick();
    for (int i = 0; i < 4; i++) tick();
    chk("sb_empty", sb_q.size(), 32'd0);

    // WIDTH=4 build: single nibble, latency 1
    bus4.a = 4'hF;
    bus4.b = 4'h1;
    bus4.cin = 1'b0;
    bus4.in_valid = 1'b1;
    tick();
    bus4.in_valid = 1'b0;
    chk("w4_valid_lat1", {31'd0, bus4.out_valid}, 32'd0);
    tick();
    chk("w4_valid", {31'd0, bus4.out_valid}, 32'd1);
    chk("w4_sum", {28'd0, bus4.sum}, 32'd0);
    chk("w4_cout", {31'd0, bus4.cout}, 32'd1);
    tick();
    chk("w4_ready_after", {31'd0, bus4.in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
